inv_key_expansion: RTL and testbench
====================================

INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 Parameter num_rounds_p, default 7: number of inverse AES-256 schedule steps per key; legal range 1..7.
REQ-002 Port clk_i, input, 1: the block's only clock.
REQ-003 Port reset_i, input, 1: reset, synchronous, active-high.
REQ-004 Port v_i, input, 1: key_i valid.
REQ-005 Port ready_o, output, 1: block accepts key_i this cycle.
REQ-006 Port key_i, input, 256: words w[8n..8n+7], n=num_rounds_p; bit 0 is the MSB, word 0 occupies bits 0:31.
REQ-007 Port v_o, output, 1: block_o valid.
REQ-008 Port yumi_i, input, 1: consumer takes block_o; legal only while v_o=1.
REQ-009 Port block_o, output, 256: words w[8(r-1)..8(r-1)+7].
REQ-010 Port round_o, output, 4: r for the current block_o.
REQ-011 Port last_o, output, 1: high with v_o when round_o=1.

Function
REQ-012 Each step SHALL compute from W=w[i..i+7] (i=8r) the words w[i-8..i-1]; the computation order is fixed as REQ-013 then REQ-014.
REQ-013 Second half: w[i-4]=W4^SubWord(W3); w[i-4+k]=W(4+k)^W(3+k) for k=1..3.
REQ-014 First half: w[i-8]=W0^SubWord(RotWord(w[i-1]))^Rcon(r), Rcon(r)=32'h01000000<<(r-1); w[i-8+k]=Wk^W(k-1) for k=1..3.
REQ-015 The FSM SHALL have the states IDLE, CALC1, CALC2 and OUT.
REQ-016 IDLE: ready_o=1; on v_i the block SHALL load key_i, set r=num_rounds_p and move to CALC1.
REQ-017 CALC1 SHALL register the REQ-013 result and move to CALC2.
REQ-018 CALC2 SHALL register the full previous block into block_o and move to OUT.
REQ-019 OUT: v_o=1, and block_o, round_o and last_o SHALL be held stable until yumi_i.
REQ-020 OUT on yumi_i with r>1: the working state SHALL take block_o, r SHALL decrement, and the FSM SHALL move to CALC1.
REQ-021 OUT on yumi_i with r=1: the FSM SHALL move to IDLE.
REQ-022 Latency: accept on edge T; v_o SHALL be high from cycle T+3; each later block SHALL be valid 3 cycles after the previous yumi_i.
REQ-023 ready_o SHALL be 0 outside IDLE; v_i is ignored there and no input is queued.
REQ-024 v_i in the cycle of the final yumi_i SHALL NOT be accepted; it is accepted one cycle later in IDLE.
REQ-025 yumi_i while v_o=0 SHALL be ignored.
REQ-026 Exactly num_rounds_p blocks SHALL be emitted per accepted key, with round_o running num_rounds_p down to 1.

Reset
REQ-027 reset_i at any cycle, including mid-operation, SHALL force IDLE, ready_o=1 on the following cycle, v_o=0, last_o=0, round_o=0, block_o=0, and clear the working and CALC1 registers.
REQ-028 A block in flight at reset SHALL be discarded and never emitted.

Configuration
REQ-029 With INV_KEY_EXP_SINGLE_CYCLE_EN defined, CALC1 SHALL be removed and CALC2 SHALL compute REQ-013 and REQ-014 combinationally in one cycle, giving v_o at T+2 and 2 cycles per later block.
REQ-030 Without INV_KEY_EXP_SINGLE_CYCLE_EN, the split behaviour of REQ-017 to REQ-022 SHALL apply.
REQ-031 Outputs SHALL be identical in both configurations except for timing.

Structure
REQ-032 Shared package aes_pkg SHALL hold the word width (32), the block width (256), the Rcon function and the FSM state enum.
REQ-033 Sub-module inv_key_step SHALL hold the REQ-013 and REQ-014 datapath and instantiate sub_bytes #(4) twice.
REQ-034 The FSM, r counter and registers SHALL stay in inv_key_expansion.

Verification
REQ-035 Input: key 000102...1f forward-expanded to w56..w63, v_i=1, yumi_i=1 on every v_o. Required: 7 blocks, round_o 7..1, each block equal to the forward model, final block_o = 000102030405...1e1f with last_o=1.
REQ-036 Input: same key with yumi_i held low for 5 cycles per block. Required: block_o and round_o stable throughout, no block lost.
REQ-037 Input: reset_i pulsed during the 3rd block's CALC2. Required: cycle after reset has v_o=0 and ready_o=1; a new key then restarts at round_o=7.
REQ-038 Input: v_i held high continuously. Required: a second key is accepted only the cycle after the final yumi_i (ready_o rises at that point).
REQ-039 Input: num_rounds_p=1, key w8..w15 of 000102...1f. Required: one block = 000102...1f, last_o=1, v_o at T+3, or T+2 with INV_KEY_EXP_SINGLE_CYCLE_EN.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: word/block widths, round constant and
// the controller state encoding used by inv_key_expansion.
package aes_pkg;

  localparam int word_w  = 32;
  localparam int block_w = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC1,
    ST_CALC2,
    ST_OUT
  } state_e;

  // Round constant for schedule step r (r >= 1), byte in the top of the word.
  function automatic logic [word_w-1:0] rcon(input logic [3:0] r);
    return 32'h0100_0000 << (r - 4'd1);
  endfunction

endpackage

// File: rtl/inv_key_step.sv
// One inverse AES-256 schedule step: hi_o is the recovered second half
// w[i-4..i-1]; lo_o is the first half w[i-8..i-5], built from hi_i's last word.
module inv_key_step
  import aes_pkg::*;
(
  input  logic [block_w-1:0]  work_i,
  input  logic [4*word_w-1:0] hi_i,
  input  logic [3:0]          round_i,
  output logic [4*word_w-1:0] hi_o,
  output logic [4*word_w-1:0] lo_o
);

  logic [word_w-1:0] w [8];
  logic [word_w-1:0] sw_hi;
  logic [word_w-1:0] sw_lo;
  logic [word_w-1:0] rot_w;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w[k] = work_i[block_w-1-word_w*k -: word_w];
    end
  end

  assign rot_w = {hi_i[23:0], hi_i[31:24]};

  sub_bytes #(.num_bytes_p(4)) u_sub_hi (.data_i(w[3]),  .data_o(sw_hi));
  sub_bytes #(.num_bytes_p(4)) u_sub_lo (.data_i(rot_w), .data_o(sw_lo));

  assign hi_o = {w[4] ^ sw_hi, w[5] ^ w[4], w[6] ^ w[5], w[7] ^ w[6]};
  assign lo_o = {w[0] ^ sw_lo ^ rcon(round_i), w[1] ^ w[0], w[2] ^ w[1], w[3] ^ w[2]};

endmodule

// File: rtl/sub_bytes.sv
// AES S-box applied to num_bytes_p bytes in parallel; the S-box is derived
// from the GF(2^8) inverse (x^254) followed by the affine transform.
module sub_bytes #(
  parameter int num_bytes_p = 4
) (
  input  logic [8*num_bytes_p-1:0] data_i,
  output logic [8*num_bytes_p-1:0] data_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] pw;
    inv = 8'h01;
    pw  = b;
    // 254 = 8'b1111_1110: multiply in every squared power except b^1.
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gf_mul(inv, pw);
      pw = gf_mul(pw, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  for (genvar g = 0; g < num_bytes_p; g++) begin : g_byte
    assign data_o[8*g +: 8] = sbox(data_i[8*g +: 8]);
  end

endmodule

// File: rtl/inv_key_expansion.sv
// Walks an AES-256 key schedule backwards, emitting one 256-bit block per step
// over a valid/yumi handshake. Define INV_KEY_EXP_SINGLE_CYCLE_EN to fold both
// halves of a step into a single compute cycle.
module inv_key_expansion
  import aes_pkg::*;
#(
  parameter int num_rounds_p = 7
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [block_w-1:0] key_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [block_w-1:0] block_o,
  output logic [3:0]         round_o,
  output logic               last_o
);

  localparam logic [3:0] num_rounds_c = 4'(num_rounds_p);

`ifdef INV_KEY_EXP_SINGLE_CYCLE_EN
  localparam state_e calc_first_c = ST_CALC2;
`else
  localparam state_e calc_first_c = ST_CALC1;
`endif

  state_e              state_q;
  logic [block_w-1:0]  work_q;
  logic [3:0]          r_q;
  logic [block_w-1:0]  block_q;
  logic [3:0]          round_q;
  logic                v_q;
  logic                ready_q;
  logic                last_q;
  logic [4*word_w-1:0] hi_d;
  logic [4*word_w-1:0] lo_d;
  logic [4*word_w-1:0] hi_sel;

  inv_key_step u_step (
    .work_i (work_q),
    .hi_i   (hi_sel),
    .round_i(r_q),
    .hi_o   (hi_d),
    .lo_o   (lo_d)
  );

`ifdef INV_KEY_EXP_SINGLE_CYCLE_EN
  assign hi_sel = hi_d;
`else
  logic [4*word_w-1:0] calc1_q;
  assign hi_sel = calc1_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: the datapath registers are cleared too, so nothing from an
      // aborted key can leak into block_o after reset.
      state_q <= ST_IDLE;
      work_q  <= '0;
      r_q     <= '0;
      block_q <= '0;
      round_q <= '0;
      v_q     <= 1'b0;
      ready_q <= 1'b1;
      last_q  <= 1'b0;
`ifndef INV_KEY_EXP_SINGLE_CYCLE_EN
      calc1_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (v_i) begin
            work_q  <= key_i;
            r_q     <= num_rounds_c;
            ready_q <= 1'b0;
            state_q <= calc_first_c;
          end
        end
`ifndef INV_KEY_EXP_SINGLE_CYCLE_EN
        ST_CALC1: begin
          calc1_q <= hi_d;
          state_q <= ST_CALC2;
        end
`endif
        ST_CALC2: begin
          block_q <= {lo_d, hi_sel};
          round_q <= r_q;
          last_q  <= (r_q == 4'd1);
          v_q     <= 1'b1;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          if (yumi_i) begin
            v_q    <= 1'b0;
            last_q <= 1'b0;
            if (r_q > 4'd1) begin
              work_q  <= block_q;
              r_q     <= r_q - 4'd1;
              state_q <= calc_first_c;
            end else begin
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o = ready_q;
  assign v_o     = v_q;
  assign block_o = block_q;
  assign round_o = round_q;
  assign last_o  = last_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Self-checking bench for inv_key_expansion: a forward AES-256 key schedule
// model supplies every expected block; latency follows INV_KEY_EXP_SINGLE_CYCLE_EN.
module tb_inv_key_expansion;

`ifdef INV_KEY_EXP_SINGLE_CYCLE_EN
  localparam int lat = 2;
`else
  localparam int lat = 3;
`endif
  localparam int n_c = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_i, v_i, yumi_i, ready_o, v_o, last_o;
  logic [255:0] key_i, block_o;
  logic [3:0]   round_o;
  logic         v1_i, yumi1_i, ready1_o, v1_o, last1_o;
  logic [255:0] key1_i, block1_o;
  logic [3:0]   round1_o;

  inv_key_expansion #(.num_rounds_p(n_c)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .key_i(key_i),
    .v_o(v_o), .yumi_i(yumi_i), .block_o(block_o), .round_o(round_o), .last_o(last_o)
  );

  inv_key_expansion #(.num_rounds_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v1_i), .ready_o(ready1_o), .key_i(key1_i),
    .v_o(v1_o), .yumi_i(yumi1_i), .block_o(block1_o), .round_o(round1_o), .last_o(last1_o)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  sbox_t [256];
  logic [31:0] w_m    [72];

  // S-box from the generator-3 walk over GF(2^8), independent of the RTL form.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  // Forward AES-256 schedule, continued past w59 so w[8n..8n+7] exists.
  task automatic expand(input logic [255:0] k);
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w_m[i] = k[255-32*i -: 32];
    for (int i = 8; i < 72; i++) begin
      t = w_m[i-1];
      if (i % 8 == 0) t = subw({t[23:0], t[31:24]}) ^ (32'h0100_0000 << (i/8 - 1));
      else if (i % 8 == 4) t = subw(t);
      w_m[i] = w_m[i-8] ^ t;
    end
  endtask

  function automatic logic [255:0] blk(input int base);
    logic [255:0] b;
    for (int j = 0; j < 8; j++) b[255-32*j -: 32] = w_m[base+j];
    return b;
  endfunction

  // Full key through the n_c-round DUT, holding yumi off for 'hold' cycles per block.
  task automatic run_key(input logic [255:0] k, input int hold, input string tag);
    logic [255:0] exp_b;
    int cnt;
    expand(k);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL %s ready_before_accept: got %b want 1", tag, ready_o);
    end
    v_i = 1'b1; key_i = blk(8*n_c);
    @(negedge clk);
    v_i = 1'b0;
    for (int r = n_c; r >= 1; r--) begin
      cnt = 1;
      while (v_o !== 1'b1 && cnt < 20) begin
        @(negedge clk); cnt++;
      end
      exp_b = blk(8*(r-1));
      checks++;
      if (cnt != lat) begin
        errors++; $display("FAIL %s latency r=%0d: got %0d want %0d", tag, r, cnt, lat);
      end
      checks++;
      if (block_o !== exp_b) begin
        errors++; $display("FAIL %s block r=%0d: got %h want %h", tag, r, block_o, exp_b);
      end
      checks++;
      if (round_o !== 4'(r) || last_o !== 1'(r == 1)) begin
        errors++;
        $display("FAIL %s round/last r=%0d: got %0d/%b want %0d/%b", tag, r, round_o, last_o, r, r == 1);
      end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if (v_o !== 1'b1 || block_o !== exp_b || round_o !== 4'(r) || ready_o !== 1'b0) begin
          errors++;
          $display("FAIL %s hold r=%0d h=%0d: got v=%b rnd=%0d rdy=%b blk=%h want v=1 rnd=%0d rdy=0 blk=%h",
                   tag, r, h, v_o, round_o, ready_o, block_o, r, exp_b);
        end
      end
      yumi_i = 1'b1;
      @(negedge clk);
      yumi_i = 1'b0;
    end
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL %s end_state: got v=%b rdy=%b want v=0 rdy=1", tag, v_o, ready_o);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0 || last_o !== 1'b0 || round_o !== 4'd0 || block_o !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b last=%b rnd=%0d blk=%h want 1 0 0 0 0",
               ready_o, v_o, last_o, round_o, block_o);
    end
    yumi_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (v_o !== 1'b0 || ready_o !== 1'b1) begin
        errors++; $display("FAIL idle_yumi: got v=%b rdy=%b want v=0 rdy=1", v_o, ready_o);
      end
    end
    yumi_i = 1'b0;
  endtask

  task automatic test_main();
    run_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 0, "main");
  endtask

  task automatic test_backpressure();
    run_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 5, "backpressure");
  endtask

  task automatic test_random();
    logic [255:0] k;
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
      run_key(k, int'($urandom_range(0, 2)), "random");
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k;
    int cnt;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    expand(k);
    v_i = 1'b1; key_i = blk(8*n_c);
    @(negedge clk);
    v_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      cnt = 1;
      while (v_o !== 1'b1 && cnt < 20) begin
        @(negedge clk); cnt++;
      end
      yumi_i = 1'b1;
      @(negedge clk);
      yumi_i = 1'b0;
    end
    repeat (lat - 2) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1 || round_o !== 4'd0 || last_o !== 1'b0 || block_o !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: got v=%b rdy=%b rnd=%0d last=%b blk=%h want 0 1 0 0 0",
               v_o, ready_o, round_o, last_o, block_o);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (v_o !== 1'b0) begin
        errors++; $display("FAIL mid_reset_discard: got v=%b want 0", v_o);
      end
    end
    run_key(k, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [255:0] ka, kb, top_b;
    logic [255:0] exp_a [1:n_c];
    logic [255:0] exp_b [1:n_c];
    int cnt, nblk;
    for (int j = 0; j < 8; j++) begin
      ka[32*j +: 32] = $urandom;
      kb[32*j +: 32] = $urandom;
    end
    expand(kb);
    for (int r = 1; r <= n_c; r++) exp_b[r] = blk(8*(r-1));
    top_b = blk(8*n_c);
    expand(ka);
    for (int r = 1; r <= n_c; r++) exp_a[r] = blk(8*(r-1));
    v_i = 1'b1; key_i = blk(8*n_c);
    @(negedge clk);
    key_i = top_b;
    for (int r = n_c; r >= 1; r--) begin
      cnt = 1;
      while (v_o !== 1'b1 && cnt < 20) begin
        checks++;
        if (ready_o !== 1'b0) begin
          errors++; $display("FAIL b2b_busy_ready: got %b want 0", ready_o);
        end
        @(negedge clk); cnt++;
      end
      checks++;
      if (block_o !== exp_a[r] || round_o !== 4'(r)) begin
        errors++; $display("FAIL b2b_block_a r=%0d: got %0d %h want %0d %h", r, round_o, block_o, r, exp_a[r]);
      end
      yumi_i = 1'b1;
      @(negedge clk);
      yumi_i = 1'b0;
    end
    checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_rise: got rdy=%b v=%b want 1 0", ready_o, v_o);
    end
    @(negedge clk);
    v_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_second_accept: got rdy=%b want 0", ready_o);
    end
    for (int r = n_c; r >= 1; r--) begin
      cnt = 1;
      while (v_o !== 1'b1 && cnt < 20) begin
        @(negedge clk); cnt++;
      end
      checks++;
      if (block_o !== exp_b[r] || round_o !== 4'(r)) begin
        errors++; $display("FAIL b2b_block_b r=%0d: got %0d %h want %0d %h", r, round_o, block_o, r, exp_b[r]);
      end
      if (r == 1) v_i = 1'b1;
      yumi_i = 1'b1;
      @(negedge clk);
      yumi_i = 1'b0;
    end
    checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0) begin
      errors++; $display("FAIL b2b_final_yumi_vi: got rdy=%b v=%b want 1 0", ready_o, v_o);
    end
    @(negedge clk);
    v_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_late_accept: got rdy=%b want 0", ready_o);
    end
    nblk = 0;
    for (int r = n_c; r >= 1; r--) begin
      cnt = 1;
      while (v_o !== 1'b1 && cnt < 20) begin
        @(negedge clk); cnt++;
      end
      if (v_o === 1'b1) nblk++;
      yumi_i = 1'b1;
      @(negedge clk);
      yumi_i = 1'b0;
    end
    checks++;
    if (nblk != n_c || ready_o !== 1'b1) begin
      errors++; $display("FAIL b2b_drain: got %0d blocks rdy=%b want %0d blocks rdy=1", nblk, ready_o, n_c);
    end
  endtask

  task automatic test_single_round();
    logic [255:0] k;
    int cnt;
    k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    expand(k);
    checks++;
    if (ready1_o !== 1'b1) begin
      errors++; $display("FAIL n1_ready: got %b want 1", ready1_o);
    end
    v1_i = 1'b1; key1_i = blk(8);
    @(negedge clk);
    v1_i = 1'b0;
    cnt = 1;
    while (v1_o !== 1'b1 && cnt < 20) begin
      @(negedge clk); cnt++;
    end
    checks++;
    if (cnt != lat) begin
      errors++; $display("FAIL n1_latency: got %0d want %0d", cnt, lat);
    end
    checks++;
    if (block1_o !== k || round1_o !== 4'd1 || last1_o !== 1'b1) begin
      errors++; $display("FAIL n1_block: got %0d %b %h want 1 1 %h", round1_o, last1_o, block1_o, k);
    end
    yumi1_i = 1'b1;
    @(negedge clk);
    yumi1_i = 1'b0;
    checks++;
    if (v1_o !== 1'b0 || ready1_o !== 1'b1 || last1_o !== 1'b0) begin
      errors++; $display("FAIL n1_end: got v=%b rdy=%b last=%b want 0 1 0", v1_o, ready1_o, last1_o);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; key_i = '0;
    v1_i = 1'b0; yumi1_i = 1'b0; key1_i = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_main();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_single_round();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
